// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
//   Reads bytes from a synchronous FIFO (registered read data, one-cycle read
//   latency, per-entry last flag) and serializes each one onto a UART line:
//   start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high; issue a FIFO read as soon as the FIFO is non-empty
// LATCH  | FIFO read data valid; capture byte, last flag and parity bit
// START  | start bit (tx=0)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when PARITY != 0)
// STOP   | stop bit (tx=1); done pulses issued on the exiting edge
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   fifo_empty     FIFO empty flag
//   fifo_dout      FIFO read data, valid the cycle after an accepted read
//   fifo_dout_last FIFO last flag, qualified like fifo_dout
//   fifo_rd_en     FIFO read strobe (combinational)
//   tx             UART serial line, idle high, registered
//   busy           high while a byte is fetched or on the line
//   byte_done      one-cycle pulse after every stop bit
//   frame_done     one-cycle pulse after the stop bit of a last-flagged byte

module uart_tx_fifo_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_dout_last,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  last_q, last_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  byte_done_q, byte_done_d;
    logic                  frame_done_q, frame_done_d;

    logic baud_end;
    assign baud_end = (baud_q == BAUD_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            last_q       <= 1'b0;
            par_q        <= 1'b0;
            tx_q         <= 1'b1;
            byte_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            par_q        <= par_d;
            tx_q         <= tx_d;
            byte_done_q  <= byte_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic; tx is computed here so it changes on the same edge
    // as the state transition that starts the corresponding bit.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        last_d       = last_q;
        par_d        = par_q;
        tx_d         = tx_q;
        byte_done_d  = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = S_LATCH;
                end
            end

            S_LATCH: begin
                shift_d = fifo_dout;
                last_d  = fifo_dout_last;
                // Odd parity is the inverse of the even (XOR) bit.
                par_d   = (^fifo_dout) ^ (PARITY == 2);
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = S_START;
            end

            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    baud_d       = '0;
                    byte_done_d  = 1'b1;
                    frame_done_d = last_q;
                    state_d      = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        fifo_rd_en = (state_q == S_IDLE) && !fifo_empty && !rst;
        busy       = (state_q != S_IDLE);
    end

    assign tx         = tx_q;
    assign byte_done  = byte_done_q;
    assign frame_done = frame_done_q;

endmodule
